// File: rtl/keypad_entry_ctrl.sv
// Keypad operand entry: debounces a 1-9 / CLEAR / ENTER keypad, shifts BCD digits
// into operands A and B, and strobes valid when both are complete.
module keypad_entry_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int DIGITS     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8:0]            key,
  input  logic                  key_clr,
  input  logic                  key_ent,
  output logic [4*DIGITS-1:0]   num_a,
  output logic [4*DIGITS-1:0]   num_b,
  output logic                  sel_b,
  output logic                  valid,
  output logic                  err,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, COMMIT, RELEASE} state_t;

  state_t        state, nxt_state;
  logic [10:0]   v, v_cap, nxt_v_cap;
  logic [7:0]    cnt, nxt_cnt;
  logic [2:0]    dig_cnt, nxt_dig_cnt;
  logic          done, nxt_done;
  logic [W-1:0]  nxt_a, nxt_b;
  logic          nxt_sel, nxt_valid, nxt_err;
  logic [W-1:0]  a_t, b_t;
  logic          s_t;
  logic [2:0]    c_t;
  logic [3:0]    dig_val;
  logic          multi;

  assign v         = {key_ent, key_clr, key};
  assign multi     = (v_cap & (v_cap - 11'd1)) != 11'd0;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      v_cap   <= '0;
      cnt     <= '0;
      dig_cnt <= '0;
      done    <= 1'b0;
      num_a   <= '0;
      num_b   <= '0;
      sel_b   <= 1'b0;
      valid   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nxt_state;
      v_cap   <= nxt_v_cap;
      cnt     <= nxt_cnt;
      dig_cnt <= nxt_dig_cnt;
      done    <= nxt_done;
      num_a   <= nxt_a;
      num_b   <= nxt_b;
      sel_b   <= nxt_sel;
      valid   <= nxt_valid;
      err     <= nxt_err;
      busy    <= (nxt_state != IDLE);
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_v_cap   = v_cap;
    nxt_cnt     = cnt;
    nxt_dig_cnt = dig_cnt;
    nxt_done    = done;
    nxt_a       = num_a;
    nxt_b       = num_b;
    nxt_sel     = sel_b;
    nxt_valid   = 1'b0;
    nxt_err     = 1'b0;
    a_t         = num_a;
    b_t         = num_b;
    s_t         = sel_b;
    c_t         = dig_cnt;
    dig_val     = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (v_cap[i]) dig_val = 4'(i + 1);
    end

    case (state)
      IDLE: begin
        if (v != 11'd0) begin
          nxt_v_cap = v;
          nxt_cnt   = 8'd1;
          nxt_state = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        // Any change in the sample vector (bounce or extra key) abandons the event
        if (v == v_cap) begin
          nxt_cnt = cnt + 8'd1;
          if (cnt + 8'd1 == 8'(DEB_CYCLES)) nxt_state = COMMIT;
        end else begin
          nxt_state = IDLE;
        end
      end
      COMMIT: begin
        nxt_state = RELEASE;
        nxt_cnt   = 8'd0;
        if (multi) begin
          nxt_err = 1'b1;
        end else if (v_cap[9]) begin
          nxt_a       = '0;
          nxt_b       = '0;
          nxt_sel     = 1'b0;
          nxt_dig_cnt = 3'd0;
          nxt_done    = 1'b0;
        end else if (v_cap[10]) begin
          if (!sel_b) begin
            nxt_sel     = 1'b1;
            nxt_dig_cnt = 3'd0;
          end else begin
            nxt_valid = 1'b1;
            nxt_done  = 1'b1;
            nxt_sel   = 1'b0;
          end
        end else begin
          // A digit after a completed pair starts a fresh entry
          if (done) begin
            a_t      = '0;
            b_t      = '0;
            s_t      = 1'b0;
            c_t      = 3'd0;
            nxt_done = 1'b0;
          end
          nxt_a       = a_t;
          nxt_b       = b_t;
          nxt_sel     = s_t;
          nxt_dig_cnt = c_t;
          if (c_t < 3'(DIGITS)) begin
            if (s_t) nxt_b = (b_t << 4) | W'(dig_val);
            else     nxt_a = (a_t << 4) | W'(dig_val);
            nxt_dig_cnt = c_t + 3'd1;
          end else begin
            nxt_err = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (v == 11'd0) begin
          nxt_cnt = cnt + 8'd1;
          if (cnt + 8'd1 == 8'(DEB_CYCLES)) nxt_state = IDLE;
        end else begin
          nxt_cnt = 8'd0;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: table of key events with expected operands, a
// cycle-stamped expectation queue checked by a monitor, plus corner-case sequences.
module tb_keypad_entry_ctrl;

  localparam int DEB = 4;
  localparam int DIG = 2;
  localparam logic [10:0] K_ENT = 11'h400;
  localparam logic [10:0] K_CLR = 11'h200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] vin = '0;
  logic [7:0]  num_a, num_b;
  logic        sel_b, valid, err, busy;
  logic [1:0]  fsm_state;

  keypad_entry_ctrl #(.DEB_CYCLES(DEB), .DIGITS(DIG)) dut (
    .clk(clk), .rst(rst), .key(vin[8:0]), .key_clr(vin[9]), .key_ent(vin[10]),
    .num_a(num_a), .num_b(num_b), .sel_b(sel_b), .valid(valid), .err(err),
    .busy(busy), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] v;
    logic [7:0]  a, b;
    logic        sel, vld, er;
  } vec_t;

  typedef struct packed {
    int         due;
    logic [7:0] pre_a, pre_b, a, b;
    logic       sel, vld, er;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic [7:0] last_a = '0, last_b = '0;
  vec_t       vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] kv(input int n);
    logic [10:0] one = 11'd1;
    return one << (n - 1);
  endfunction

  // Monitor: expected results become due a fixed number of edges after the first sample
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("num_a", 32'(num_a), 32'(e.a));
        chk("num_b", 32'(num_b), 32'(e.b));
        chk("sel_b", 32'(sel_b), 32'(e.sel));
        chk("valid", 32'(valid), 32'(e.vld));
        chk("err",   32'(err),   32'(e.er));
      end else begin
        if (exp_q.size() != 0 && exp_q[0].due == cyc + 1) begin
          chk("num_a_early", 32'(num_a), 32'(exp_q[0].pre_a));
          chk("num_b_early", 32'(num_b), 32'(exp_q[0].pre_b));
        end
        chk("stray_valid", 32'(valid), 32'd0);
        chk("stray_err",   32'(err),   32'd0);
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b,
                          input logic sel, input logic vld, input logic er);
    exp_t e;
    e.due   = cyc + 1 + DEB;
    e.pre_a = last_a;
    e.pre_b = last_b;
    e.a = a; e.b = b; e.sel = sel; e.vld = vld; e.er = er;
    exp_q.push_back(e);
    last_a = a;
    last_b = b;
  endtask

  task automatic press(input logic [10:0] v, input int hold, input logic [7:0] a,
                       input logic [7:0] b, input logic sel, input logic vld, input logic er);
    @(negedge clk);
    push_exp(a, b, sel, vld, er);
    vin = v;
    repeat (hold) @(negedge clk);
    vin = '0;
    repeat ($urandom_range(DEB + 6, DEB + 2)) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{kv(3),        8'h03, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{kv(7),        8'h37, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{K_ENT,        8'h37, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{kv(4),        8'h37, 8'h04, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{kv(2),        8'h37, 8'h42, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{K_ENT,        8'h37, 8'h42, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{kv(5),        8'h05, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{kv(2)|kv(6),  8'h05, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{kv(1),        8'h51, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{kv(2),        8'h51, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{K_CLR,        8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{kv(1),        8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{kv(2),        8'h12, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{kv(3),        8'h12, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{K_ENT,        8'h12, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{K_ENT,        8'h12, 8'h00, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    vin = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_num_a", 32'(num_a), 32'd0);
    chk("rst_num_b", 32'(num_b), 32'd0);
    chk("rst_sel_b", 32'(sel_b), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      press(vecs[i].v, $urandom_range(DEB + 4, DEB), vecs[i].a, vecs[i].b,
            vecs[i].sel, vecs[i].vld, vecs[i].er);
    end
    press(kv(9), 6, 8'h09, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();

    // Bounce: two high samples, one low, then a clean press -> one event
    press(K_CLR, 6, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vin = kv(5);
    repeat (2) @(negedge clk);
    vin = '0;
    @(negedge clk);
    push_exp(8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
    vin = kv(5);
    repeat (6) @(negedge clk);
    vin = '0;
    repeat (12) @(negedge clk);
    drain();

    // Press one sample short of the debounce length is ignored
    vin = kv(5);
    repeat (DEB - 1) @(negedge clk);
    vin = '0;
    repeat (12) @(negedge clk);
    chk("short_press_a", 32'(num_a), 32'h05);

    // Long hold produces a single digit
    press(K_CLR, 6, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    press(kv(8), 40, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();
    chk("hold_a", 32'(num_a), 32'h08);
    press(kv(3), 6, 8'h83, 8'h00, 1'b0, 1'b0, 1'b0);
    press(K_ENT, 6, 8'h83, 8'h00, 1'b1, 1'b0, 1'b0);
    press(K_CLR, 6, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();
    chk("clr_sel_b", 32'(sel_b), 32'd0);

    // Reset during debounce of key 9
    press(kv(8), 6, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();
    vin = kv(9);
    repeat (2) @(negedge clk);
    chk("debounce_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    vin = '0;
    @(negedge clk);
    rst = 1'b0;
    last_a = '0;
    last_b = '0;
    chk("mid_rst_num_a", 32'(num_a), 32'd0);
    chk("mid_rst_num_b", 32'(num_b), 32'd0);
    chk("mid_rst_sel_b", 32'(sel_b), 32'd0);
    chk("mid_rst_busy",  32'(busy),  32'd0);
    repeat (10) @(negedge clk);
    chk("key9_dropped_a", 32'(num_a), 32'd0);
    press(kv(4), 6, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
